// File: rtl/time_set_ctrl.sv
// Button-driven editor for the clock time and the alarm: loads a BCD buffer, edits one digit at a time,
// then issues a single-cycle load strobe. Edge detection is internal; COMMIT follows the final nxt edge by one cycle.
module time_set_ctrl #(
    parameter int TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_time,
    input  logic       set_alarm,
    input  logic       nxt,
    input  logic       inc,
    input  logic       cancel,
    input  logic [1:0] H_cur1,
    input  logic [3:0] H_cur0,
    input  logic [3:0] M_cur1,
    input  logic [3:0] M_cur0,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       editing,
    output logic [1:0] edit_sel
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

    state_t        state_q, state_d;
    logic          tgt_alarm_q, tgt_alarm_d;
    logic [4:0]    btn_prev_q;
    logic [4:0]    btn_now, edges;
    logic [1:0]    h1_q, h1_d;
    logic [3:0]    h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
    logic [1:0]    ah1_q, ah1_d;
    logic [3:0]    ah0_q, ah0_d, am1_q, am1_d, am0_q, am0_d;
    logic [1:0]    sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    h0_lim;

    // Bit order: {cancel, inc, nxt, set_alarm, set_time}
    assign btn_now = {cancel, inc, nxt, set_alarm, set_time};
    assign edges   = btn_now & ~btn_prev_q;
    assign h0_lim  = (h1_q == 2'd2) ? 4'd3 : 4'd9;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tgt_alarm_q <= 1'b0;
            btn_prev_q  <= 5'b11111;  // a button held through reset release must not look like a press
            h1_q  <= '0; h0_q  <= '0; m1_q  <= '0; m0_q  <= '0;
            ah1_q <= '0; ah0_q <= '0; am1_q <= '0; am0_q <= '0;
            sel_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tgt_alarm_q <= tgt_alarm_d;
            btn_prev_q  <= btn_now;
            h1_q  <= h1_d;  h0_q  <= h0_d;  m1_q  <= m1_d;  m0_q  <= m0_d;
            ah1_q <= ah1_d; ah0_q <= ah0_d; am1_q <= am1_d; am0_q <= am0_d;
            sel_q <= sel_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tgt_alarm_d = tgt_alarm_q;
        h1_d  = h1_q;  h0_d  = h0_q;  m1_d  = m1_q;  m0_d  = m0_q;
        ah1_d = ah1_q; ah0_d = ah0_q; am1_d = am1_q; am0_d = am0_q;
        sel_d = sel_q;
        cnt_d = cnt_q;
        LD_time  = 1'b0;
        LD_alarm = 1'b0;
        editing  = 1'b0;

        case (state_q)
            IDLE: begin
                if (edges[0]) begin
                    state_d     = EDIT;
                    tgt_alarm_d = 1'b0;
                    h1_d = H_cur1; h0_d = H_cur0; m1_d = M_cur1; m0_d = M_cur0;
                    sel_d = 2'd0;
                    cnt_d = '0;
                end else if (edges[1]) begin
                    state_d     = EDIT;
                    tgt_alarm_d = 1'b1;
                    h1_d = ah1_q; h0_d = ah0_q; m1_d = am1_q; m0_d = am0_q;
                    sel_d = 2'd0;
                    cnt_d = '0;
                end
            end
            EDIT: begin
                editing = 1'b1;
                if (edges[4]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (edges != 5'd0) begin
                    cnt_d = '0;
                    if (edges[3]) begin
                        case (sel_q)
                            2'd0: begin
                                if (h1_q == 2'd2) begin
                                    h1_d = 2'd0;
                                end else begin
                                    h1_d = h1_q + 2'd1;
                                    if (h1_d == 2'd2 && h0_q > 4'd3) h0_d = 4'd3;
                                end
                            end
                            2'd1: h0_d = (h0_q >= h0_lim) ? 4'd0 : h0_q + 4'd1;
                            2'd2: m1_d = (m1_q >= 4'd5)   ? 4'd0 : m1_q + 4'd1;
                            default: m0_d = (m0_q >= 4'd9) ? 4'd0 : m0_q + 4'd1;
                        endcase
                    end
                    // nxt is evaluated after inc so a combined press commits the incremented digit
                    if (edges[2]) begin
                        if (sel_q == 2'd3) state_d = COMMIT;
                        else               sel_d   = sel_q + 2'd1;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            COMMIT: begin
                state_d  = IDLE;
                LD_time  = ~tgt_alarm_q;
                LD_alarm = tgt_alarm_q;
                if (tgt_alarm_q) begin
                    ah1_d = h1_q; ah0_d = h0_q; am1_d = m1_q; am0_d = m0_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign H_in1    = h1_q;
    assign H_in0    = h0_q;
    assign M_in1    = m1_q;
    assign M_in0    = m0_q;
    assign edit_sel = sel_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: expected load strobes are queued as stimulus is driven and popped when a strobe appears.
module tb_time_set_ctrl;

    localparam int TO = 20;
    localparam logic [4:0] B_TIME  = 5'b00001;
    localparam logic [4:0] B_ALARM = 5'b00010;
    localparam logic [4:0] B_NXT   = 5'b00100;
    localparam logic [4:0] B_INC   = 5'b01000;
    localparam logic [4:0] B_CAN   = 5'b10000;

    typedef struct packed {
        logic        alarm;
        logic [15:0] t;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] btn;
    logic [1:0] H_cur1;
    logic [3:0] H_cur0, M_cur1, M_cur0;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm, editing;
    logic [1:0] edit_sel;

    int  n_cmp = 0;
    int  n_err = 0;
    ev_t sb_q[$];
    ev_t mon_e;

    time_set_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .set_time(btn[0]), .set_alarm(btn[1]), .nxt(btn[2]), .inc(btn[3]), .cancel(btn[4]),
        .H_cur1(H_cur1), .H_cur0(H_cur0), .M_cur1(M_cur1), .M_cur0(M_cur0),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .editing(editing), .edit_sel(edit_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] bufv();
        return {2'b00, H_in1, H_in0, M_in1, M_in0};
    endfunction

    task automatic set_cur(input logic [15:0] t);
        H_cur1 = t[13:12]; H_cur0 = t[11:8]; M_cur1 = t[7:4]; M_cur0 = t[3:0];
    endtask

    // One-cycle press; returns just after the edge-sampling clock edge
    task automatic press(input logic [4:0] m);
        @(posedge clk); #1 btn = m;
        @(posedge clk); #1 btn = '0;
    endtask

    task automatic expect_ld(input logic alarm, input logic [15:0] t);
        ev_t e;
        e.alarm = alarm;
        e.t     = t;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (LD_time && LD_alarm) check("both_strobes", 1, 0);
        if (LD_time || LD_alarm) begin
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", {30'd0, LD_alarm, LD_time}, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("strobe", {LD_alarm, LD_time, bufv()}, {mon_e.alarm, ~mon_e.alarm, mon_e.t});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        btn   = '0;
        set_cur(16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check("rst_editing", editing, 0);
        check("rst_sel", edit_sel, 0);
        check("rst_buf", bufv(), 16'h0000);
        check("rst_ld", {LD_alarm, LD_time}, 0);
        reset = 1'b1;

        // Edit the time 10:19 -> 12:19; a set_time edge mid-edit and one in COMMIT are ignored
        set_cur(16'h1019);
        press(B_TIME);
        check("time_enter", editing, 1);
        check("time_load", bufv(), 16'h1019);
        check("time_sel0", edit_sel, 0);
        press(B_NXT);
        check("time_sel1", edit_sel, 1);
        press(B_INC);
        press(B_INC);
        set_cur(16'h2345);
        press(B_TIME);
        check("edit_ignores_set", bufv(), 16'h1219);
        press(B_NXT);
        press(B_NXT);
        check("time_sel3", edit_sel, 3);
        expect_ld(1'b0, 16'h1219);
        @(posedge clk); #1 btn = B_NXT;
        @(posedge clk); #1 btn = B_TIME;
        check("commit_latency", LD_time, 1);
        @(posedge clk); #1 btn = '0;
        check("commit_ignores_edge", editing, 0);
        check("strobe_single", LD_time, 0);

        // Alarm 00:00 -> 10:20, then reload from the alarm register
        press(B_ALARM);
        check("alarm_load_rst", bufv(), 16'h0000);
        press(B_INC);
        press(B_NXT);
        press(B_NXT);
        press(B_INC);
        press(B_INC);
        press(B_NXT);
        expect_ld(1'b1, 16'h1020);
        press(B_NXT);
        check("alarm_latency", LD_alarm, 1);
        @(posedge clk); #1;
        press(B_ALARM);
        check("alarm_reload", bufv(), 16'h1020);
        press(B_CAN);
        check("alarm_cancel", editing, 0);

        // Digit wrapping and the H0 clamp
        set_cur(16'h1945);
        press(B_TIME);
        press(B_INC);
        check("h1_clamp", bufv(), 16'h2345);
        press(B_NXT);
        press(B_INC);
        check("h0_wrap_at_2x", bufv(), 16'h2045);
        press(B_CAN);
        set_cur(16'h2359);
        press(B_TIME | B_ALARM);
        check("simul_sel_time", bufv(), 16'h2359);
        press(B_INC);
        check("h1_wrap", bufv(), 16'h0359);
        press(B_NXT);
        press(B_NXT);
        press(B_INC);
        check("m1_wrap", bufv(), 16'h0309);
        press(B_NXT);
        expect_ld(1'b0, 16'h0300);
        press(B_INC | B_NXT);
        check("inc_nxt_commit", LD_time, 1);
        @(posedge clk); #1;

        // Cancel overrides inc/nxt; alarm register untouched
        set_cur(16'h1019);
        press(B_TIME);
        press(B_INC);
        press(B_CAN | B_INC | B_NXT);
        check("cancel_idle", editing, 0);
        check("cancel_buf", bufv(), 16'h2019);
        check("cancel_sel", edit_sel, 0);
        press(B_ALARM);
        check("alarm_kept", bufv(), 16'h1020);
        press(B_CAN);

        // Inactivity timeout
        press(B_TIME);
        repeat (TO - 3) @(posedge clk);
        #1 check("before_timeout", editing, 1);
        repeat (5) @(posedge clk);
        #1 check("after_timeout", editing, 0);
        check("timeout_buf", bufv(), 16'h1019);

        // Reset mid-edit with nxt held through release
        press(B_TIME);
        press(B_NXT);
        press(B_INC);
        btn   = B_NXT;
        reset = 1'b0;
        #1;
        check("midrst_editing", editing, 0);
        check("midrst_sel", edit_sel, 0);
        check("midrst_buf", bufv(), 16'h0000);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("postrst_editing", editing, 0);
        check("postrst_sel", edit_sel, 0);
        btn = '0;
        press(B_ALARM);
        check("postrst_alarm", bufv(), 16'h0000);
        press(B_CAN);
        repeat (3) @(posedge clk);
        #1;

        check("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1000: clk cycles without a button edge in EDIT before the edit is abandoned.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately.
REQ-004 set_time, set_alarm, nxt, inc, cancel  input  1 each  button levels, synchronous to clk, already debounced.
REQ-005 H_cur1  input  2; H_cur0, M_cur1, M_cur0  input  4 each  current clock time, BCD.
REQ-006 H_in1  output  2; H_in0, M_in1, M_in0  output  4 each  edit buffer, BCD, driven continuously.
REQ-007 LD_time, LD_alarm  output  1 each  single-cycle load strobes to the clock core.
REQ-008 editing  output  1  high while in EDIT.
REQ-009 edit_sel  output  2  selected digit: 0=H1, 1=H0, 2=M1, 3=M0.

Function
REQ-010 Each button SHALL be rising-edge detected internally: edge = level high now and low in previous cycle; only edges act.
REQ-011 States SHALL be IDLE, EDIT, COMMIT; target flag SHALL record TIME or ALARM.
REQ-012 IDLE, set_time edge -> EDIT, target=TIME, buffer <= H_cur1..M_cur0, edit_sel=0.
REQ-013 IDLE, set_alarm edge -> EDIT, target=ALARM, buffer <= internal alarm register, edit_sel=0.
REQ-014 Simultaneous set_time and set_alarm edges in IDLE SHALL select TIME.
REQ-015 EDIT, inc edge SHALL increment selected digit with wrap: H1 0->1->2->0; M1 0..5->0; M0 0..9->0; H0 0..9->0 when H1<2, 0..3->0 when H1=2.
REQ-016 When H1 becomes 2 and H0>3, H0 SHALL be clamped to 3 in the same cycle.
REQ-017 EDIT, nxt edge SHALL advance edit_sel by 1; nxt edge at edit_sel=3 -> COMMIT.
REQ-018 Simultaneous inc and nxt edges SHALL apply the increment to the current digit, then advance.
REQ-019 EDIT, cancel edge -> IDLE, no strobe, alarm register unchanged; cancel SHALL override inc/nxt in the same cycle.
REQ-020 Inactivity counter SHALL clear on entry to EDIT and on any button edge; reaching TIMEOUT -> IDLE as for cancel.
REQ-021 set_time/set_alarm edges in EDIT SHALL be ignored.
REQ-022 COMMIT SHALL last exactly one cycle: LD_time (TIME) or LD_alarm (ALARM) high, H_in*/M_in* = final buffer; next state IDLE.
REQ-023 COMMIT with target ALARM SHALL copy buffer into alarm register.
REQ-024 Strobes SHALL be low in all states except COMMIT; at most one strobe high in any cycle.
REQ-025 All button edges during COMMIT SHALL be ignored.
REQ-026 Latency: final nxt edge sampled at cycle N -> strobe high in cycle N+1.

Reset
REQ-027 Reset low SHALL force: state IDLE, buffer 00:00, alarm register 00:00, edit_sel 0, editing 0, LD_time 0, LD_alarm 0, counter 0.
REQ-028 Edge-history registers SHALL reset to 1, so a button held through reset release produces no edge.
REQ-029 Reset mid-EDIT or in COMMIT SHALL abort with no strobe after release.

Verification
REQ-030 H_cur=10:19, set_time edge, inc on H0 twice, nxt x4 -> single LD_time pulse, H_in=12:19.
REQ-031 set_alarm edge, edit to 10:20, commit -> LD_alarm one cycle, H_in=10:20; second set_alarm edge reloads 10:20 into buffer.
REQ-032 Buffer 19:xx, inc on H1 -> H1=2, H0=3; inc H0 -> 0; inc H1 at 2 -> 0.
REQ-033 EDIT, inc+nxt same cycle at edit_sel=3 -> M0 incremented, then COMMIT strobe next cycle.
REQ-034 EDIT then cancel (or TIMEOUT idle cycles) -> IDLE, editing=0, no strobe, alarm register unchanged.
REQ-035 Reset asserted mid-EDIT with nxt held -> all outputs at reset values, no edge or strobe after release.
